rv32m_mul_issue: RTL and testbench

- Initiator-side sequencer for the iterative multiplier datapath/control pair.
- Accepts decoded RV32M multiply requests from the core over a valid/ready channel.
- Maps funct3 onto the multiplier's signed_A/signed_B/upper controls, fires a one-cycle start, waits for done, and returns the 32-bit result with its destination tag on a valid/ready response channel.
- Sits between the core's execute stage and the multiplier top level. Handles kill and a hung-multiplier watchdog.

---
 rtl/rv32m_mul_issue.sv | 140 ++++++++++++++
 tb/tb_rv32m_mul_issue.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_mul_issue.sv
// Issue sequencer between the core's execute stage and the iterative multiplier.
// Optional zero-operand bypass is enabled by defining RV32M_MUL_ZERO_FAST_EN.
module rv32m_mul_issue #(
  parameter int unsigned TAG_W   = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [2:0]       req_funct3_i,
  input  logic [31:0]      req_rs1_i,
  input  logic [31:0]      req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             kill_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             rsp_err_o,
  output logic             mult_en_o,
  output logic [31:0]      op_A_o,
  output logic [31:0]      op_B_o,
  output logic             signed_A_o,
  output logic             signed_B_o,
  output logic             upper_o,
  input  logic [31:0]      mult_result_i,
  input  logic             mult_done_i
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  localparam logic [7:0] WD_LIMIT = 8'(TIMEOUT);

  state_t     state;
  logic [7:0] wd_cnt;
  logic [7:0] wd_next;
  logic       killed;
  logic       legal;
  logic       fast;
  logic       dec_sa;
  logic       dec_sb;
  logic       dec_up;
  logic       wait_end;

  always_comb begin
    legal   = ~req_funct3_i[2];
    dec_sa  = (req_funct3_i[1:0] == 2'b01) || (req_funct3_i[1:0] == 2'b10);
    dec_sb  = (req_funct3_i[1:0] == 2'b01);
    dec_up  = (req_funct3_i[1:0] != 2'b00);
    wd_next = wd_cnt + 8'd1;
    // done has priority over the watchdog when both land in the same cycle
    wait_end = mult_done_i || (wd_next == WD_LIMIT);
`ifdef RV32M_MUL_ZERO_FAST_EN
    fast = (req_rs1_i == '0) || (req_rs2_i == '0);
`else
    fast = 1'b0;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state       <= IDLE;
      wd_cnt      <= '0;
      killed      <= 1'b0;
      req_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_data_o  <= '0;
      rsp_tag_o   <= '0;
      rsp_err_o   <= 1'b0;
      mult_en_o   <= 1'b0;
      op_A_o      <= '0;
      op_B_o      <= '0;
      signed_A_o  <= 1'b0;
      signed_B_o  <= 1'b0;
      upper_o     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            rsp_tag_o   <= req_tag_i;
            killed      <= 1'b0;
            req_ready_o <= 1'b0;
            if (!legal || fast) begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= '0;
              rsp_err_o   <= ~legal;
            end else begin
              state      <= ISSUE;
              mult_en_o  <= 1'b1;
              op_A_o     <= req_rs1_i;
              op_B_o     <= req_rs2_i;
              signed_A_o <= dec_sa;
              signed_B_o <= dec_sb;
              upper_o    <= dec_up;
            end
          end
        end
        ISSUE: begin
          mult_en_o <= 1'b0;
          wd_cnt    <= '0;
          if (kill_i) killed <= 1'b1;
          state <= WAIT;
        end
        WAIT: begin
          if (wait_end) begin
            // a killed request still waits out the multiplier, then drops silently
            if (killed || kill_i) begin
              state       <= IDLE;
              req_ready_o <= 1'b1;
            end else begin
              state       <= RESP;
              rsp_valid_o <= 1'b1;
              rsp_data_o  <= mult_done_i ? mult_result_i : '0;
              rsp_err_o   <= ~mult_done_i;
            end
          end else begin
            wd_cnt <= wd_next;
            if (kill_i) killed <= 1'b1;
          end
        end
        RESP: begin
          if (rsp_ready_i || kill_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            req_ready_o <= 1'b1;
          end
        end
        default: begin
          state       <= IDLE;
          req_ready_o <= 1'b1;
          rsp_valid_o <= 1'b0;
          mult_en_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rv32m_mul_issue.sv
// Directed-vector bench for rv32m_mul_issue with a small iterative multiplier model.
module tb_rv32m_mul_issue;

  localparam int unsigned TW  = 5;
  localparam int unsigned TMO = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [2:0]    req_funct3 = '0;
  logic [31:0]   req_rs1 = '0;
  logic [31:0]   req_rs2 = '0;
  logic [TW-1:0] req_tag = '0;
  logic          kill = 1'b0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [31:0]   rsp_data;
  logic [TW-1:0] rsp_tag;
  logic          rsp_err;
  logic          mult_en;
  logic [31:0]   op_a;
  logic [31:0]   op_b;
  logic          sa;
  logic          sb;
  logic          up;
  logic [31:0]   mult_result;
  logic          mult_done;

  int unsigned total = 0;
  int unsigned passed = 0;

  rv32m_mul_issue #(.TAG_W(TW), .TIMEOUT(TMO)) dut (
    .clk_i(clk), .rst_i(rst_n),
    .req_valid_i(req_valid), .req_ready_o(req_ready), .req_funct3_i(req_funct3),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag), .kill_i(kill),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data),
    .rsp_tag_o(rsp_tag), .rsp_err_o(rsp_err), .mult_en_o(mult_en),
    .op_A_o(op_a), .op_B_o(op_b), .signed_A_o(sa), .signed_B_o(sb), .upper_o(up),
    .mult_result_i(mult_result), .mult_done_i(mult_done)
  );

  always #5 clk = ~clk;

  // Multiplier model: done is seen at the mlat-th rising edge after the start pulse.
  int unsigned mlat = 8;
  bit          hang = 1'b0;
  logic        busy;
  int unsigned rem;
  logic [31:0] mres;

  function automatic logic [31:0] mul_model(input logic [31:0] a, input logic [31:0] b,
                                            input logic s_a, input logic s_b, input logic hi);
    logic [63:0] a64, b64, p;
    a64 = s_a ? {{32{a[31]}}, a} : {32'h0, a};
    b64 = s_b ? {{32{b[31]}}, b} : {32'h0, b};
    p   = a64 * b64;
    return hi ? p[63:32] : p[31:0];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= 1'b0;
      rem  <= 0;
      mres <= '0;
    end else if (mult_en) begin
      busy <= 1'b1;
      rem  <= mlat - 1;
      mres <= mul_model(op_a, op_b, sa, sb, up);
    end else if (busy) begin
      if (mult_done) busy <= 1'b0;
      else if (rem != 0) rem <= rem - 1;
    end
  end

  assign mult_done   = busy && (rem == 0) && !hang;
  assign mult_result = mult_done ? mres : ~mres;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  typedef struct {
    logic [2:0]    f3;
    logic [31:0]   rs1;
    logic [31:0]   rs2;
    logic [TW-1:0] tag;
    logic [2:0]    ctrl;
    logic [31:0]   data;
    logic          err;
    int unsigned   lat;
    int unsigned   pulses;
  } vec_t;

  function automatic vec_t mk(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic [TW-1:0] tag, input logic [2:0] ctrl, input logic [31:0] data,
                              input logic err, input int unsigned lat, input int unsigned pulses);
    vec_t v;
    v.f3 = f3; v.rs1 = rs1; v.rs2 = rs2; v.tag = tag; v.ctrl = ctrl;
    v.data = data; v.err = err; v.lat = lat; v.pulses = pulses;
    return v;
  endfunction

  task automatic run_vec(input vec_t v, input bit kill_at_accept);
    int unsigned lat;
    int unsigned pulses;
    logic [2:0]  ctrl;
    logic [63:0] ops;
    @(negedge clk);
    check("req_ready_before", req_ready, 1);
    req_valid  = 1'b1;
    req_funct3 = v.f3;
    req_rs1    = v.rs1;
    req_rs2    = v.rs2;
    req_tag    = v.tag;
    kill       = kill_at_accept;
    @(negedge clk);
    req_valid  = 1'b0;
    kill       = 1'b0;
    req_rs1    = $urandom;
    req_rs2    = $urandom;
    req_tag    = ~v.tag;
    lat = 1; pulses = 0; ctrl = '0; ops = '0;
    while (!rsp_valid && lat < 40) begin
      if (mult_en) begin
        pulses++;
        ctrl = {sa, sb, up};
        ops  = {op_a, op_b};
      end
      @(negedge clk);
      lat++;
    end
    check("rsp_latency", 64'(lat), 64'(v.lat));
    check("mult_en_pulses", 64'(pulses), 64'(v.pulses));
    if (v.pulses != 0) begin
      check("controls", ctrl, v.ctrl);
      check("operands", ops, {v.rs1, v.rs2});
    end
    check("rsp_valid", rsp_valid, 1);
    check("rsp_data", rsp_data, v.data);
    check("rsp_tag", rsp_tag, v.tag);
    check("rsp_err", rsp_err, v.err);
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("rsp_valid_after_hs", rsp_valid, 0);
    check("req_ready_after_hs", req_ready, 1);
  endtask

  task automatic check_reset_outputs(input string name);
    check(name, {req_ready, rsp_valid, mult_en, sa, sb, up, rsp_err}, 7'b1000000);
    check({name, "_data"}, {rsp_data, op_a, op_b}, '0);
    check({name, "_tag"}, rsp_tag, '0);
  endtask

  vec_t vecs[10];

  initial begin
    int unsigned lat;
    bit          seen;

    vecs[0] = mk(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'h03, 3'b000, 32'hFFFF_FFEB, 1'b0, 10, 1);
    vecs[1] = mk(3'b001, 32'h8000_0000, 32'h8000_0000, 5'h11, 3'b111, 32'h4000_0000, 1'b0, 10, 1);
    vecs[2] = mk(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 5'h1F, 3'b101, 32'hFFFF_FFFF, 1'b0, 10, 1);
    vecs[3] = mk(3'b011, 32'hFFFF_FFFF, 32'h0000_0002, 5'h00, 3'b001, 32'h0000_0001, 1'b0, 10, 1);
    vecs[4] = mk(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h0A, 3'b001, 32'hFFFF_FFFE, 1'b0, 10, 1);
    vecs[5] = mk(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'h15, 3'b111, 32'h0000_0000, 1'b0, 10, 1);
    vecs[6] = mk(3'b000, 32'h1234_5678, 32'h0000_0010, 5'h07, 3'b000, 32'h2345_6780, 1'b0, 10, 1);
`ifdef RV32M_MUL_ZERO_FAST_EN
    vecs[7] = mk(3'b000, 32'h0000_1234, 32'h0000_0000, 5'h19, 3'b000, 32'h0000_0000, 1'b0, 1, 0);
`else
    vecs[7] = mk(3'b000, 32'h0000_1234, 32'h0000_0000, 5'h19, 3'b000, 32'h0000_0000, 1'b0, 10, 1);
`endif
    vecs[8] = mk(3'b100, 32'h0000_0003, 32'h0000_0004, 5'h02, 3'b000, 32'h0000_0000, 1'b1, 1, 0);
    vecs[9] = mk(3'b111, 32'h0000_0005, 32'h0000_0006, 5'h1C, 3'b000, 32'h0000_0000, 1'b1, 1, 0);

    repeat (3) @(negedge clk);
    check_reset_outputs("reset_state");
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], 1'b0);

    // Illegal request held in RESP while the core stalls.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b100; req_rs1 = 32'h9; req_rs2 = 32'h9; req_tag = 5'h0D;
    @(negedge clk);
    req_valid = 1'b0;
    check("illegal_no_en", mult_en, 0);
    for (int c = 0; c < 5; c++) begin
      check("hold_valid", rsp_valid, 1);
      check("hold_payload", {rsp_err, rsp_tag, rsp_data}, {1'b1, 5'h0D, 32'h0});
      check("hold_req_ready", req_ready, 0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("hold_released", {rsp_valid, req_ready}, 2'b01);

    // Watchdog: multiplier never finishes.
    hang = 1'b1;
    run_vec(mk(3'b000, 32'h3, 32'h5, 5'h04, 3'b000, 32'h0, 1'b1, TMO + 2, 1), 1'b0);
    hang = 1'b0;

    // Done arrives in the same cycle the watchdog would expire.
    mlat = TMO;
    run_vec(mk(3'b000, 32'h3, 32'h5, 5'h05, 3'b000, 32'hF, 1'b0, TMO + 2, 1), 1'b0);
    mlat = 8;

    // Kill while waiting: no response, ready the cycle after done.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b000; req_rs1 = 32'h7; req_rs2 = 32'h3; req_tag = 5'h09;
    @(negedge clk);
    req_valid = 1'b0;
    check("kill_issue_en", mult_en, 1);
    @(negedge clk);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    lat = 3; seen = 1'b0;
    while (!req_ready && lat < 40) begin
      if (rsp_valid) seen = 1'b1;
      @(negedge clk);
      lat++;
    end
    check("kill_wait_ready_lat", 64'(lat), 64'd10);
    check("kill_wait_no_rsp", {seen, rsp_valid}, 2'b00);

    // Kill in IDLE does not block acceptance.
    run_vec(vecs[6], 1'b1);

    // Kill in RESP drops the response.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b101; req_tag = 5'h12;
    @(negedge clk);
    req_valid = 1'b0;
    check("kill_resp_pre", rsp_valid, 1);
    kill = 1'b1;
    @(negedge clk);
    kill = 1'b0;
    check("kill_resp_drop", {rsp_valid, req_ready}, 2'b01);

    // Asynchronous reset in the middle of WAIT.
    @(negedge clk);
    req_valid = 1'b1; req_funct3 = 3'b001; req_rs1 = 32'hABCD_0001; req_rs2 = 32'h0000_1111; req_tag = 5'h1E;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("pre_reset_busy", {req_ready, rsp_valid, sa, sb, up}, 5'b00111);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(vecs[0], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got hung, expected finish");
    $fatal(1);
  end

endmodule
